// File: rtl/lcd_pkg.sv
// Shared constants, FSM state type and address-counter helper for the HD44780
// bus responder model.
package lcd_pkg;
    localparam int SHORT_CYCLES_DEF = 2000;
    localparam int LONG_CYCLES_DEF  = 76000;
    localparam int DDRAM_DEPTH      = 80;

    localparam logic [6:0] AC_LAST = 7'(DDRAM_DEPTH - 1);
    localparam logic [7:0] BLANK   = 8'h20;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_CLEAR     = 8'h01;
    localparam logic [7:0] OP_HOME      = 8'h02;
    localparam logic [7:0] OP_ENTRY     = 8'h04;
    localparam logic [7:0] OP_DISPLAY   = 8'h08;
    localparam logic [7:0] OP_SHIFT     = 8'h10;
    localparam logic [7:0] OP_FUNCTION  = 8'h20;
    localparam logic [7:0] OP_CGRAM     = 8'h40;
    localparam logic [7:0] OP_DDRAM     = 8'h80;
    localparam logic [7:0] OP_DDRAM_MAX = 8'hCF;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_SWEEP} state_e;

    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        if (inc) return (ac == AC_LAST) ? 7'd0 : ac + 7'd1;
        return (ac == 7'd0) ? AC_LAST : ac - 7'd1;
    endfunction
endpackage

// File: rtl/lcd_bus_sync.sv
// Two-flop synchronizer for the LCD writer bus with falling-edge detect on E.
// rs/d travel with e so the decoded word lines up with the detected edge.
module lcd_bus_sync (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       e_i,
    input  logic       rs_i,
    input  logic [7:0] d_i,
    output logic       rs_o,
    output logic [7:0] d_o,
    output logic       fall_o
);
    logic       e1_q, e2_q, e3_q;
    logic       rs1_q, rs2_q;
    logic [7:0] d1_q, d2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            e1_q  <= 1'b0;
            e2_q  <= 1'b0;
            e3_q  <= 1'b0;
            rs1_q <= 1'b0;
            rs2_q <= 1'b0;
            d1_q  <= 8'h00;
            d2_q  <= 8'h00;
        end else begin
            e1_q  <= e_i;
            e2_q  <= e1_q;
            e3_q  <= e2_q;
            rs1_q <= rs_i;
            rs2_q <= rs1_q;
            d1_q  <= d_i;
            d2_q  <= d1_q;
        end
    end

    assign fall_o = e3_q & ~e2_q;
    assign rs_o   = rs2_q;
    assign d_o    = d2_q;
endmodule

// File: rtl/lcd_responder.sv
// Behavioural HD44780 slave: decodes writer transfers, models the busy flag,
// the DDRAM contents and the address counter, and flags protocol violations.
module lcd_responder
    import lcd_pkg::*;
#(
    parameter int SHORT_CYCLES = SHORT_CYCLES_DEF,
    parameter int LONG_CYCLES  = LONG_CYCLES_DEF
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rs,
    input  logic       e,
    input  logic [7:0] d,
    output logic       busy,
    output logic       cmd_valid,
    output logic [8:0] cmd_code,
    output logic       protocol_error,
    output logic [6:0] addr_counter,
    output logic       display_on,
    output logic       entry_inc,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data
);
    localparam int CW = $clog2(LONG_CYCLES + 1);
    localparam logic [CW-1:0] SHORT_LOAD = CW'(SHORT_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LOAD  = CW'(LONG_CYCLES - 1);

    logic       sync_rs, fall;
    logic [7:0] sync_d;

    lcd_bus_sync u_sync (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .e_i    (e),
        .rs_i   (rs),
        .d_i    (d),
        .rs_o   (sync_rs),
        .d_o    (sync_d),
        .fall_o (fall)
    );

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    sw_q, sw_d, ac_q, ac_d;
    logic          disp_q, disp_d, inc_q, inc_d, err_q, err_d, cv_q, cv_d;
    logic [8:0]    code_q, code_d;
    logic [7:0]    rd_q;
    logic          wr_en, ld_short, ld_long;
    logic [6:0]    wr_addr;
    logic [7:0]    wr_data;
    logic [7:0]    mem [DDRAM_DEPTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        sw_d     = sw_q;
        ac_d     = ac_q;
        disp_d   = disp_q;
        inc_d    = inc_q;
        err_d    = err_q;
        cv_d     = 1'b0;
        code_d   = code_q;
        wr_en    = 1'b0;
        wr_addr  = ac_q;
        wr_data  = sync_d;
        ld_short = 1'b0;
        ld_long  = 1'b0;

        // The sweep never hands over to IDLE before the last location is blanked.
        unique case (state_q)
            ST_SWEEP: begin
                wr_en   = 1'b1;
                wr_addr = sw_q;
                wr_data = BLANK;
                if (sw_q == AC_LAST) state_d = (cnt_q == '0) ? ST_IDLE : ST_EXEC;
                else                 sw_d    = sw_q + 7'd1;
            end
            ST_EXEC: if (cnt_q == '0) state_d = ST_IDLE;
            default: ;
        endcase

        if (fall) begin
            cv_d   = 1'b1;
            code_d = {sync_rs, sync_d};
            if (state_q != ST_IDLE) err_d = 1'b1;
            if (state_q != ST_SWEEP) begin
                if (sync_rs) begin
                    wr_en    = 1'b1;
                    ac_d     = ac_step(ac_q, inc_q);
                    ld_short = 1'b1;
                end else if (sync_d == OP_NOP) begin
                    ld_short = 1'b0;
                end else if (sync_d == OP_CLEAR) begin
                    state_d = ST_SWEEP;
                    sw_d    = 7'd0;
                    cnt_d   = LONG_LOAD;
                    ac_d    = 7'd0;
                    inc_d   = 1'b1;
                end else if ((sync_d & ~8'h01) == OP_HOME) begin
                    ac_d    = 7'd0;
                    ld_long = 1'b1;
                end else if (sync_d < OP_DISPLAY) begin
                    inc_d    = sync_d[1];
                    ld_short = (sync_d >= OP_ENTRY);
                end else if (sync_d < OP_SHIFT) begin
                    disp_d   = sync_d[2];
                    ld_short = 1'b1;
                end else if (sync_d < OP_FUNCTION) begin
                    if (!sync_d[3]) ac_d = ac_step(ac_q, sync_d[2]);
                    ld_short = 1'b1;
                end else if (sync_d < OP_CGRAM) begin
                    ld_short = 1'b1;
                end else if (sync_d < OP_DDRAM) begin
                    ld_short = 1'b1;
                end else begin
                    if (sync_d <= OP_DDRAM_MAX) ac_d  = sync_d[6:0];
                    else                        err_d = 1'b1;
                    ld_short = 1'b1;
                end
            end
        end

        if (ld_short) begin
            state_d = ST_EXEC;
            cnt_d   = SHORT_LOAD;
        end
        if (ld_long) begin
            state_d = ST_EXEC;
            cnt_d   = LONG_LOAD;
        end
    end

    // Reset parks the FSM at the start of the power-on sweep.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_SWEEP;
            cnt_q   <= LONG_LOAD;
            sw_q    <= 7'd0;
            ac_q    <= 7'd0;
            disp_q  <= 1'b0;
            inc_q   <= 1'b1;
            err_q   <= 1'b0;
            cv_q    <= 1'b0;
            code_q  <= 9'd0;
            rd_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
            ac_q    <= ac_d;
            disp_q  <= disp_d;
            inc_q   <= inc_d;
            err_q   <= err_d;
            cv_q    <= cv_d;
            code_q  <= code_d;
            rd_q    <= (rd_addr < 7'(DDRAM_DEPTH)) ? mem[rd_addr] : 8'h00;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign busy           = (state_q != ST_IDLE);
    assign cmd_valid      = cv_q;
    assign cmd_code       = code_q;
    assign protocol_error = err_q;
    assign addr_counter   = ac_q;
    assign display_on     = disp_q;
    assign entry_inc      = inc_q;
    assign rd_data        = rd_q;
endmodule

// File: tb/tb_lcd_responder.sv
// Bench for lcd_responder: transaction-level model of the LCD controller,
// directed scenarios with literal expectations, then randomized traffic.
module tb_lcd_responder;
    localparam int SHORT    = 20;
    localparam int LONG     = 120;
    localparam int DEPTH    = 80;
    localparam int LONG_EFF = (LONG > DEPTH) ? LONG : DEPTH;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       rs = 1'b0, e = 1'b0;
    logic [7:0] d = 8'h00;
    logic [6:0] rd_addr = 7'd0;
    logic       busy, cmd_valid, protocol_error, display_on, entry_inc;
    logic [8:0] cmd_code;
    logic [6:0] addr_counter;
    logic [7:0] rd_data;

    always #5 clock = ~clock;

    lcd_responder #(.SHORT_CYCLES(SHORT), .LONG_CYCLES(LONG)) dut (
        .clock(clock), .reset_n(reset_n), .rs(rs), .e(e), .d(d),
        .busy(busy), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .protocol_error(protocol_error), .addr_counter(addr_counter),
        .display_on(display_on), .entry_inc(entry_inc),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model (transaction level) ----------------
    int         cyc = 0, busy_end = LONG_EFF, sw_base = 0, sw_last = DEPTH;
    int         m_ac = 0, exp_rd = -1, due_cyc = 0;
    bit         m_inc = 1, m_disp = 0, m_err = 0, exp_cv = 0;
    bit         prev_e = 0, due_v = 0, due_rs = 0;
    logic [7:0] due_d = 8'h00;
    logic [8:0] exp_code = 9'd0;
    int         mem_m [DEPTH];

    task automatic m_reset();
        cyc = 0; busy_end = LONG_EFF; sw_base = 0; sw_last = DEPTH;
        m_ac = 0; m_inc = 1; m_disp = 0; m_err = 0;
        exp_cv = 0; exp_code = 9'd0; exp_rd = -1; prev_e = 0; due_v = 0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = -1;
    endtask

    function automatic int wrap(input int a, input bit up);
        return up ? (a + 1) % DEPTH : (a + DEPTH - 1) % DEPTH;
    endfunction

    task automatic m_exec(input int t, input bit r, input logic [7:0] v);
        exp_cv = 1; exp_code = {r, v};
        if (t <= busy_end) m_err = 1;
        if (t > sw_base && t <= sw_last) return;
        if (r) begin
            mem_m[m_ac] = int'(v); m_ac = wrap(m_ac, m_inc); busy_end = t + SHORT;
        end else if (v == 8'h00) begin
            busy_end = busy_end;
        end else if (v == 8'h01) begin
            sw_base = t; sw_last = t + DEPTH; m_ac = 0; m_inc = 1; busy_end = t + LONG_EFF;
        end else if (v < 8'h04) begin
            m_ac = 0; busy_end = t + LONG;
        end else begin
            busy_end = t + SHORT;
            if (v < 8'h08) m_inc = v[1];
            else if (v < 8'h10) m_disp = v[2];
            else if (v < 8'h20) begin
                if (!v[3]) m_ac = wrap(m_ac, v[2]);
            end else if (v >= 8'hD0) m_err = 1;
            else if (v >= 8'h80) m_ac = int'(v) - 128;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clock);
            if (!reset_n) m_reset();
            else begin
                cyc++;
                exp_rd = (rd_addr >= 7'(DEPTH)) ? 0 : mem_m[rd_addr];
                if (cyc > sw_base && cyc <= sw_last) mem_m[cyc - sw_base - 1] = 32'h20;
                exp_cv = 0;
                if (due_v && due_cyc == cyc) begin
                    due_v = 0;
                    m_exec(cyc, due_rs, due_d);
                end
                if (prev_e && !e) begin
                    due_v = 1; due_cyc = cyc + 2; due_rs = rs; due_d = d;
                end
                prev_e = e;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clock);
            #1;
            if (!reset_n) begin
                chk("rst_busy", busy, 1);
                chk("rst_cmd_valid", cmd_valid, 0);
                chk("rst_cmd_code", cmd_code, 0);
                chk("rst_err", protocol_error, 0);
                chk("rst_ac", addr_counter, 0);
                chk("rst_disp", display_on, 0);
                chk("rst_inc", entry_inc, 1);
                chk("rst_rd_data", rd_data, 0);
            end else begin
                chk("busy", busy, (cyc < busy_end) ? 1 : 0);
                chk("cmd_valid", cmd_valid, exp_cv);
                if (exp_cv) chk("cmd_code", cmd_code, exp_code);
                chk("protocol_error", protocol_error, m_err);
                chk("addr_counter", addr_counter, m_ac);
                chk("display_on", display_on, m_disp);
                chk("entry_inc", entry_inc, m_inc);
                if (exp_rd >= 0) chk("rd_data", rd_data, exp_rd);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            rd_addr = 7'($urandom_range(0, 127));
        end
    endtask

    task automatic send(input bit r, input logic [7:0] v);
        bit seen;
        @(negedge clock);
        rs = r; d = v; e = 1'b1;
        @(negedge clock);
        @(negedge clock);
        e = 1'b0;
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clock);
            #1;
            if (cmd_valid === 1'b1) seen = 1;
        end
        chk("send_cmd_valid_seen", seen, 1);
    endtask

    task automatic rd_chk(input string nm, input int a, input int exp);
        @(negedge clock);
        rd_addr = 7'(a);
        @(negedge clock);
        #1;
        chk(nm, rd_data, exp);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < LONG_EFF + 50) begin
            n++;
            @(negedge clock);
            #1;
        end
    endtask

    task automatic all_blank(input string nm);
        for (int a = 0; a < DEPTH; a++) rd_chk(nm, a, 8'h20);
    endtask

    initial begin
        int n, k;
        bit r;
        logic [7:0] v;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("lit_reset_busy", busy, 1);
        chk("lit_reset_inc", entry_inc, 1);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        count_busy(n);
        chk("lit_poweron_busy_len", n, LONG);
        all_blank("lit_poweron_blank");
        rd_chk("lit_rd_out_of_range", 100, 0);
        chk("lit_poweron_ac", addr_counter, 0);

        send(0, 8'h85); idle(SHORT + 5);
        send(1, 8'h41); idle(SHORT + 5);
        send(1, 8'h42); idle(SHORT + 5);
        rd_chk("lit_ddram5", 5, 8'h41);
        rd_chk("lit_ddram6", 6, 8'h42);
        chk("lit_ac7", addr_counter, 7);
        chk("lit_no_err", protocol_error, 0);

        send(0, 8'h04); idle(SHORT + 5);
        send(0, 8'h80); idle(SHORT + 5);
        send(1, 8'h33); idle(SHORT + 5);
        rd_chk("lit_ddram0", 0, 8'h33);
        chk("lit_ac_wrap79", addr_counter, 79);

        send(1, 8'h55); idle(5);
        send(1, 8'h56);
        count_busy(n);
        chk("lit_busy_extended", n, SHORT);
        chk("lit_err_busy_write", protocol_error, 1);
        rd_chk("lit_ddram79", 79, 8'h55);
        rd_chk("lit_ddram78", 78, 8'h56);

        @(negedge clock); reset_n = 1'b0;
        @(negedge clock); reset_n = 1'b1;
        idle(LONG + 5);
        send(0, 8'h85); idle(SHORT + 5);
        send(0, 8'hD0); idle(SHORT + 5);
        chk("lit_err_illegal_addr", protocol_error, 1);
        chk("lit_ac_unchanged", addr_counter, 5);
        send(0, 8'h01); idle(35);
        send(1, 8'h77); idle(LONG + 10);
        all_blank("lit_clear_blank");
        chk("lit_clear_ac", addr_counter, 0);
        send(0, 8'h0C); idle(SHORT + 5);
        chk("lit_display_on", display_on, 1);

        send(0, 8'h01); idle(30);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("lit_midclear_busy", busy, 1);
        chk("lit_midclear_err", protocol_error, 0);
        chk("lit_midclear_disp", display_on, 0);
        chk("lit_midclear_rd", rd_data, 0);
        idle(2);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        count_busy(n);
        chk("lit_rerelease_busy_len", n, LONG);
        all_blank("lit_rerelease_blank");

        repeat (150) begin
            k = $urandom_range(0, 99);
            r = 0;
            if (k < 40) begin r = 1; v = 8'($urandom_range(0, 255)); end
            else if (k < 55) v = 8'(8'h80 + $urandom_range(0, 8'h4F));
            else if (k < 58) v = 8'(8'hD0 + $urandom_range(0, 8'h2F));
            else if (k < 61) v = 8'h01;
            else if (k < 65) v = 8'(8'h02 + $urandom_range(0, 1));
            else if (k < 70) v = 8'h00;
            else v = 8'($urandom_range(4, 8'h7F));
            send(r, v);
            idle($urandom_range(0, SHORT + 10));
        end
        idle(LONG + 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lcd_responder.md
LCD_RESPONDER -- requirements
Module: lcd_responder

Interface
REQ-001 SHALL have parameter SHORT_CYCLES, default 2000, busy duration (clocks) for ordinary commands and data writes.
REQ-002 SHALL have parameter LONG_CYCLES, default 76000, busy duration (clocks) for Clear, Home and the power-on sweep.
REQ-003 clock  in  1  single system clock; all state on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 rs  in  1  register select from the LCD writer (0 = command, 1 = data).
REQ-006 e  in  1  enable strobe from the LCD writer; a transfer completes on its falling edge.
REQ-007 d  in  8  data bus from the LCD writer.
REQ-008 busy  out  1  modelled HD44780 busy flag.
REQ-009 cmd_valid  out  1  one-cycle pulse per decoded transfer.
REQ-010 cmd_code  out  9  {rs,d} of the transfer, valid while cmd_valid is high.
REQ-011 protocol_error  out  1  sticky; set on any transfer received while busy or on an illegal address.
REQ-012 addr_counter  out  7  current DDRAM address counter (AC).
REQ-013 display_on  out  1  display on/off bit from Display Control.
REQ-014 entry_inc  out  1  entry-mode increment (1) / decrement (0).
REQ-015 rd_addr  in  7  DDRAM debug read address.
REQ-016 rd_data  out  8  DDRAM[rd_addr], registered, 1-cycle latency; 0x00 when rd_addr > 79.

Function
REQ-017 e, rs and d SHALL pass through a 2-flop synchronizer together; a falling edge SHALL be detected on the synchronized e, and cmd_valid SHALL pulse on the 3rd rising edge after e is first sampled low.
REQ-018 DDRAM SHALL be 80 x 8 with linear addresses 0..79.
REQ-019 rs=1: write d to DDRAM[AC]; advance AC per entry_inc; busy SHORT_CYCLES.
REQ-020 AC SHALL wrap 79->0 on increment and 0->79 on decrement.
REQ-021 0x00: no-op; no busy, no error.
REQ-022 0x01 Clear: sweep 0x20 into all 80 locations, one per clock; AC=0, entry_inc=1; busy LONG_CYCLES.
REQ-023 0x02-0x03 Home: AC=0; busy LONG_CYCLES.
REQ-024 0x04-0x07 Entry: entry_inc=d[1]; shift bit d[0] stored, no effect; busy SHORT_CYCLES.
REQ-025 0x08-0x0F Display Control: display_on=d[2]; cursor and blink stored; busy SHORT_CYCLES.
REQ-026 0x10-0x1F Shift: if d[3]=0, AC +1 when d[2]=1 and -1 when d[2]=0, with wrap; if d[3]=1, no change; busy SHORT_CYCLES.
REQ-027 0x20-0x3F Function Set and 0x40-0x7F CGRAM Address: fields stored, no DDRAM effect; busy SHORT_CYCLES.
REQ-028 0x80-0xCF: AC = d[6:0]; 0xD0-0xFF: AC unchanged and protocol_error set; both busy SHORT_CYCLES.
REQ-029 busy SHALL rise in the cmd_valid cycle and fall exactly N cycles later.
REQ-030 If busy=1 in the cmd_valid cycle, protocol_error SHALL be set and the transfer executed with the busy counter reloaded, including in the counter's terminal cycle.
REQ-031 While a sweep is active, transfers SHALL pulse cmd_valid and set protocol_error but SHALL NOT execute.
REQ-032 A sweep SHALL always complete before busy falls.
REQ-033 The three FSM states SHALL be IDLE, EXEC (counting) and SWEEP (counting plus fill).

Reset
REQ-034 While reset_n=0: busy=1, cmd_valid=0, cmd_code=0, protocol_error=0, addr_counter=0, display_on=0, entry_inc=1, rd_data=0, synchronizer flops=0.
REQ-035 On reset release, a power-on sweep identical to Clear SHALL run; busy SHALL stay 1 for LONG_CYCLES.
REQ-036 Reset mid-sweep or mid-command SHALL abort the operation; the sweep restarts from address 0 after release.

Structure
REQ-037 lcd_pkg SHALL hold the opcode constants, the SHORT/LONG defaults, DDRAM_DEPTH=80, BLANK=0x20 and the state enum.
REQ-038 Synchronizer plus falling-edge detect SHALL be sub-module lcd_bus_sync; DDRAM SHALL be inferred inline.

Verification
REQ-039 Release reset with no traffic -> busy high for LONG_CYCLES, then all of DDRAM reads 0x20 and AC=0.
REQ-040 Send 0x80|5, then data 0x41, 0x42 with gaps > SHORT_CYCLES -> DDRAM[5]=0x41, DDRAM[6]=0x42, AC=7, protocol_error=0.
REQ-041 Send Entry 0x04, set AC=0, write 0x33 -> DDRAM[0]=0x33, AC=79.
REQ-042 Send data write 10 cycles after a previous write -> protocol_error=1, write executed, busy extended SHORT_CYCLES from the second cmd_valid.
REQ-043 Send 0xD0 -> protocol_error=1, AC unchanged; send Clear, then data 40 cycles later -> data dropped, DDRAM all 0x20.
REQ-044 Assert reset_n=0 mid-Clear -> outputs at reset values immediately; after release, a full sweep and LONG busy.
